// File: rtl/usb_rx_pkt_ctrl.sv
// Low-speed USB receive packet controller. Sits behind usb_rx, validates
// PID, CRC16, length and DATA0/DATA1 sequencing, keeps one accepted payload
// in a local buffer and reports an ACK/NAK/none decision once per packet.

package usb_rx_pkt_pkg;
  typedef logic [3:0] pid_t;
  localparam pid_t PID_DATA0 = 4'b0011;
  localparam pid_t PID_DATA1 = 4'b1011;
  localparam logic [1:0] HS_NONE = 2'd0;
  localparam logic [1:0] HS_ACK  = 2'd1;
  localparam logic [1:0] HS_NAK  = 2'd2;
endpackage

module usb_rx_pkt_ctrl
  import usb_rx_pkt_pkg::*;
#(
  parameter int MAX_PAYLOAD = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_active,
  input  logic                           rx_valid,
  input  logic                           rx_error,
  input  logic                           toggle_clr,
  input  logic                           buf_release,
  input  logic [$clog2(MAX_PAYLOAD)-1:0] rd_addr,
  output logic [7:0]                     rd_data,
  output logic                           buf_full,
  output logic [3:0]                     buf_len,
  output pid_t                           pid,
  output logic                           pkt_done,
  output logic [1:0]                     hs,
  output logic [3:0]                     err,
  output logic                           dup
);

  localparam int DEPTH = MAX_PAYLOAD + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [15:0] CRC_RESIDUAL = 16'hB001;

  typedef enum logic [2:0] {IDLE, PID, DATA, SKIP, EVAL} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [15:0]   crc;
  logic          wr_block;
  logic          is_data;
  logic          rx_err_q, len_err_q, pid_err_q;
  logic          toggle;
  logic          armed;
  logic [7:0]    mem [DEPTH];
  logic [CW-1:0] rd_idx;

  logic          pid_ok, pid_load, pid_is_data;
  logic          set_rx_err, set_len_err, set_pid_err;
  logic          byte_en, accept;
  logic          crc_bad, too_short;
  logic [1:0]    hs_nx;
  logic [3:0]    err_nx;
  logic          dup_nx;

  // Reflected CRC16 (poly 8005, reflected A001), one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 16'hA001;
    end
    return c;
  endfunction

  assign pid_ok  = (rx_data[7:4] == ~rx_data[3:0]);
  assign rd_idx  = CW'(rd_addr);
  assign rd_data = mem[rd_idx];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode, per-byte strobes and the end-of-packet decision.
  always_comb begin
    state_nx    = state;
    pid_load    = 1'b0;
    pid_is_data = 1'b0;
    set_rx_err  = 1'b0;
    set_len_err = 1'b0;
    set_pid_err = 1'b0;
    byte_en     = 1'b0;
    accept      = 1'b0;
    crc_bad     = 1'b0;
    too_short   = 1'b0;
    hs_nx       = HS_NONE;
    err_nx      = 4'd0;
    dup_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (rx_active && armed) state_nx = PID;
      end
      PID: begin
        if (rx_error) begin
          set_rx_err = 1'b1;
          state_nx   = SKIP;
        end else if (rx_valid) begin
          if (!pid_ok) begin
            set_pid_err = 1'b1;
            state_nx    = SKIP;
          end else begin
            pid_load = 1'b1;
            if (rx_data[3:0] == PID_DATA0 || rx_data[3:0] == PID_DATA1) begin
              pid_is_data = 1'b1;
              state_nx    = DATA;
            end else begin
              state_nx = SKIP;
            end
          end
        end else if (!rx_active) begin
          set_pid_err = 1'b1;
          state_nx    = EVAL;
        end
      end
      DATA: begin
        if (rx_error) begin
          set_rx_err = 1'b1;
          state_nx   = SKIP;
        end else begin
          if (rx_valid) begin
            byte_en = 1'b1;
            if (cnt == CNT_MAX) set_len_err = 1'b1;
          end
          if (!rx_active) state_nx = EVAL;
        end
      end
      SKIP: begin
        if (!rx_active) state_nx = EVAL;
      end
      EVAL: begin
        state_nx  = IDLE;
        crc_bad   = is_data && (crc != CRC_RESIDUAL);
        too_short = is_data && (cnt < CW'(2));
        err_nx    = {rx_err_q, len_err_q | too_short, crc_bad, pid_err_q};
        if (err_nx == 4'd0 && is_data) begin
          if (wr_block) begin
            hs_nx = HS_NAK;
          end else if (pid[3] != toggle) begin
            dup_nx = 1'b1;
            hs_nx  = HS_ACK;
          end else begin
            hs_nx  = HS_ACK;
            accept = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Packet datapath: counter, CRC, error flags, toggle, buffer status and reported results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      crc       <= 16'hFFFF;
      wr_block  <= 1'b0;
      is_data   <= 1'b0;
      rx_err_q  <= 1'b0;
      len_err_q <= 1'b0;
      pid_err_q <= 1'b0;
      toggle    <= 1'b0;
      armed     <= 1'b0;
      buf_full  <= 1'b0;
      buf_len   <= 4'd0;
      pid       <= '0;
      pkt_done  <= 1'b0;
      hs        <= HS_NONE;
      err       <= 4'd0;
      dup       <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (!rx_active) armed <= 1'b1;
      if (state == IDLE) begin
        cnt       <= '0;
        crc       <= 16'hFFFF;
        is_data   <= 1'b0;
        rx_err_q  <= 1'b0;
        len_err_q <= 1'b0;
        pid_err_q <= 1'b0;
      end
      if (set_rx_err)  rx_err_q  <= 1'b1;
      if (set_len_err) len_err_q <= 1'b1;
      if (set_pid_err) pid_err_q <= 1'b1;
      if (pid_load)    pid       <= rx_data[3:0];
      if (pid_is_data) begin
        is_data  <= 1'b1;
        wr_block <= buf_full;
      end
      if (byte_en) begin
        crc <= crc16_byte(crc, rx_data);
        if (cnt < CNT_MAX) cnt <= cnt + CW'(1);
      end
      if (state == EVAL) begin
        pkt_done <= 1'b1;
        hs       <= hs_nx;
        err      <= err_nx;
        dup      <= dup_nx;
      end
      if (accept) begin
        buf_full <= 1'b1;
        buf_len  <= 4'(cnt - CW'(2));
      end else if (buf_release) begin
        buf_full <= 1'b0;
      end
      if (toggle_clr)  toggle <= 1'b0;
      else if (accept) toggle <= ~toggle;
    end
  end

  // Payload buffer write; frozen for the whole packet when it was full at PID time.
  always_ff @(posedge clk) begin
    if (byte_en && (cnt < CNT_MAX) && !wr_block) mem[cnt] <= rx_data;
  end

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Self-checking bench for usb_rx_pkt_ctrl: directed packets from the test
// plan followed by randomized traffic, all checked against a packet-level model.

module tb_usb_rx_pkt_ctrl;
  import usb_rx_pkt_pkg::*;

  localparam int MAX_PAYLOAD = 8;
  typedef logic [7:0] byte_q_t [$];

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_active = 1'b0;
  logic       rx_valid = 1'b0;
  logic       rx_error = 1'b0;
  logic       toggle_clr = 1'b0;
  logic       buf_release = 1'b0;
  logic [2:0] rd_addr = 3'd0;
  logic [7:0] rd_data;
  logic       buf_full;
  logic [3:0] buf_len;
  pid_t       pid;
  logic       pkt_done;
  logic [1:0] hs;
  logic [3:0] err;
  logic       dup;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic       exp_toggle;
  logic       model_full;
  int         model_len;
  byte_q_t    model_buf;
  pid_t       model_pid;
  logic [1:0] exp_hs;
  logic [3:0] exp_err;
  logic       exp_dup;

  // Observed results of the last packet
  logic       got_done, got_extra, got_full, got_dup;
  logic [1:0] got_hs;
  logic [3:0] got_err, got_len;
  pid_t       got_pid;

  byte_q_t pkt;

  usb_rx_pkt_ctrl #(.MAX_PAYLOAD(MAX_PAYLOAD)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_active(rx_active),
    .rx_valid(rx_valid), .rx_error(rx_error), .toggle_clr(toggle_clr),
    .buf_release(buf_release), .rd_addr(rd_addr), .rd_data(rd_data),
    .buf_full(buf_full), .buf_len(buf_len), .pid(pid), .pkt_done(pkt_done),
    .hs(hs), .err(err), .dup(dup)
  );

  always #21 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // USB CRC16 of a payload as transmitted (complemented, sent low byte first).
  function automatic logic [15:0] crc16_usb(input byte_q_t d);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (d[k]) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ d[k][b]) c = (c >> 1) ^ 16'hA001;
        else                c = c >> 1;
      end
    end
    return ~c;
  endfunction

  function automatic byte_q_t make_data(input logic [7:0] pid_byte, input int len, input bit corrupt);
    byte_q_t     p, payload;
    logic [15:0] c;
    int          k;
    p.push_back(pid_byte);
    for (int i = 0; i < len; i++) payload.push_back(8'($urandom));
    c = crc16_usb(payload);
    foreach (payload[i]) p.push_back(payload[i]);
    p.push_back(c[7:0]);
    p.push_back(c[15:8]);
    if (corrupt) begin
      k = $urandom_range(1, p.size() - 1);
      p[k] = p[k] ^ (8'd1 << $urandom_range(0, 7));
    end
    return p;
  endfunction

  task automatic model_reset();
    exp_toggle = 1'b0;
    model_full = 1'b0;
    model_len  = 0;
    model_pid  = 4'd0;
    model_buf  = {};
  endtask

  // Packet-level rules: which bytes counted, which errors, and the handshake.
  task automatic model_packet(input byte_q_t p, input int err_at);
    int          n_rx, n;
    logic [7:0]  b0;
    byte_q_t     body, payload;
    logic [15:0] c;
    exp_hs  = HS_NONE;
    exp_err = 4'd0;
    exp_dup = 1'b0;
    n_rx = (err_at < 0) ? p.size() : err_at;
    if (err_at >= 0) exp_err[3] = 1'b1;
    if (n_rx == 0) begin
      if (err_at < 0) exp_err[0] = 1'b1;
      return;
    end
    b0 = p[0];
    if (b0[7:4] != ~b0[3:0]) begin
      exp_err[0] = 1'b1;
      return;
    end
    model_pid = b0[3:0];
    if (b0[3:0] != 4'h3 && b0[3:0] != 4'hB) return;
    for (int i = 1; i < n_rx; i++) body.push_back(p[i]);
    n = n_rx - 1;
    exp_err[2] = (n < 2) || (n > MAX_PAYLOAD + 2);
    if (n < 2) begin
      exp_err[1] = 1'b1;
    end else begin
      for (int i = 0; i < n - 2; i++) payload.push_back(body[i]);
      c = crc16_usb(payload);
      exp_err[1] = ({body[n-1], body[n-2]} != c);
    end
    if (exp_err != 4'd0) return;
    if (model_full) begin
      exp_hs = HS_NAK;
    end else if (b0[3] != exp_toggle) begin
      exp_dup = 1'b1;
      exp_hs  = HS_ACK;
    end else begin
      exp_hs     = HS_ACK;
      model_full = 1'b1;
      model_len  = n - 2;
      model_buf  = payload;
      exp_toggle = ~exp_toggle;
    end
  endtask

  // Drive one packet on the usb_rx side and capture the end-of-packet report.
  task automatic applyStimulus(input byte_q_t p, input int err_at);
    int gaps;
    @(negedge clk);
    rx_active = 1'b1;
    repeat (2) @(negedge clk);
    foreach (p[i]) begin
      if (i == err_at) begin
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
      end
      rx_data  = p[i];
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      gaps = $urandom_range(0, 2);
      repeat (gaps) @(negedge clk);
    end
    rx_active = 1'b0;
    got_done  = 1'b0;
    for (int t = 0; t < 10 && !got_done; t++) begin
      @(negedge clk);
      if (pkt_done) begin
        got_done = 1'b1;
        got_hs   = hs;
        got_err  = err;
        got_dup  = dup;
        got_full = buf_full;
        got_len  = buf_len;
        got_pid  = pid;
      end
    end
    @(negedge clk);
    got_extra = pkt_done;
  endtask

  task automatic run_packet(input byte_q_t p, input int err_at, input string tag);
    applyStimulus(p, err_at);
    model_packet(p, err_at);
    checkOutput({tag, "_done"}, 32'(got_done), 32'd1);
    checkOutput({tag, "_pulse"}, 32'(got_extra), 32'd0);
    checkOutput({tag, "_hs"}, 32'(got_hs), 32'(exp_hs));
    checkOutput({tag, "_err"}, 32'(got_err), 32'(exp_err));
    checkOutput({tag, "_dup"}, 32'(got_dup), 32'(exp_dup));
    checkOutput({tag, "_full"}, 32'(got_full), 32'(model_full));
    checkOutput({tag, "_len"}, 32'(got_len), 32'(model_len));
    checkOutput({tag, "_pid"}, 32'(got_pid), 32'(model_pid));
  endtask

  task automatic check_buffer(input string tag);
    for (int i = 0; i < model_len; i++) begin
      rd_addr = 3'(i);
      #1;
      checkOutput($sformatf("%s_rd%0d", tag, i), 32'(rd_data), 32'(model_buf[i]));
    end
  endtask

  task automatic pulse_release();
    @(negedge clk);
    buf_release = 1'b1;
    @(negedge clk);
    buf_release = 1'b0;
    model_full  = 1'b0;
  endtask

  task automatic pulse_toggle_clr();
    @(negedge clk);
    toggle_clr = 1'b1;
    @(negedge clk);
    toggle_clr = 1'b0;
    exp_toggle = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_full"}, 32'(buf_full), 32'd0);
    checkOutput({tag, "_len"}, 32'(buf_len), 32'd0);
    checkOutput({tag, "_pid"}, 32'(pid), 32'd0);
    checkOutput({tag, "_done"}, 32'(pkt_done), 32'd0);
    checkOutput({tag, "_hs"}, 32'(hs), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_dup"}, 32'(dup), 32'd0);
  endtask

  initial begin
    int         kind, err_at, done_cnt;
    logic [7:0] pid_b;
    logic [7:0] tokens [4];
    tokens[0] = 8'hE1; tokens[1] = 8'h69; tokens[2] = 8'h2D; tokens[3] = 8'hA5;

    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    pkt = {8'hC3, 8'h00, 8'h00};
    run_packet(pkt, -1, "zlen");

    pulse_release();
    @(negedge clk);
    checkOutput("release", 32'(buf_full), 32'd0);

    pkt = make_data(8'h4B, 8, 1'b0);
    run_packet(pkt, -1, "full");
    check_buffer("full");

    pkt = make_data(8'hC3, 5, 1'b0);
    run_packet(pkt, -1, "blocked");
    check_buffer("blocked");
    pulse_release();

    pkt = make_data(8'hC3, 3, 1'b0);
    run_packet(pkt, -1, "pre_dup");
    pulse_release();
    pkt = make_data(8'hC3, 4, 1'b0);
    run_packet(pkt, -1, "dup");

    pkt = make_data(8'h4B, 8, 1'b1);
    run_packet(pkt, -1, "crc");
    pkt = {8'hC2, 8'h00, 8'h00};
    run_packet(pkt, -1, "badpid");
    pkt = make_data(8'h4B, 11, 1'b0);
    run_packet(pkt, -1, "overlen");
    pkt = {8'h69, 8'h15, 8'h3A};
    run_packet(pkt, -1, "token");
    pkt = make_data(8'h4B, 6, 1'b0);
    run_packet(pkt, 4, "rxerr");

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) pulse_release();
      if ($urandom_range(0, 5) == 0) pulse_toggle_clr();
      kind   = $urandom_range(0, 9);
      pid_b  = ($urandom_range(0, 1) == 1) ? 8'h4B : 8'hC3;
      err_at = -1;
      case (kind)
        0, 1, 2, 3: pkt = make_data(pid_b, $urandom_range(0, MAX_PAYLOAD), 1'b0);
        4:          pkt = make_data(pid_b, $urandom_range(1, MAX_PAYLOAD), 1'b1);
        5:          pkt = make_data(pid_b, $urandom_range(MAX_PAYLOAD + 1, MAX_PAYLOAD + 3), 1'b0);
        6:          pkt = {8'($urandom), 8'($urandom), 8'($urandom)};
        7:          pkt = {tokens[$urandom_range(0, 3)], 8'($urandom), 8'($urandom)};
        default: begin
          pkt    = make_data(pid_b, $urandom_range(2, MAX_PAYLOAD), 1'b0);
          err_at = $urandom_range(3, pkt.size() - 1);
        end
      endcase
      run_packet(pkt, err_at, $sformatf("rnd%0d", it));
      if (model_full) check_buffer($sformatf("rnd%0d", it));
    end

    @(negedge clk);
    rx_active = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_data  = (i == 0) ? 8'hC3 : 8'($urandom);
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      @(negedge clk);
    end
    reset = 1'b0;
    #5;
    check_all_zero("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data  = 8'($urandom);
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_active = 1'b0;
    done_cnt  = 0;
    repeat (8) begin
      @(negedge clk);
      if (pkt_done) done_cnt++;
    end
    checkOutput("rst_mid_no_done", 32'(done_cnt), 32'd0);
    model_reset();

    pkt = {8'hC3, 8'h00, 8'h00};
    run_packet(pkt, -1, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
